// File: rtl/rv32i_pkg.sv
// rv32i_pkg: branch funct3 encodings and 2-bit BHT counter type shared by the front end and execute.
package rv32i_pkg;
  localparam logic [2:0] BEQ  = 3'b000;
  localparam logic [2:0] BNE  = 3'b001;
  localparam logic [2:0] BLT  = 3'b100;
  localparam logic [2:0] BGE  = 3'b101;
  localparam logic [2:0] BLTU = 3'b110;
  localparam logic [2:0] BGEU = 3'b111;
  typedef logic [1:0] bht_ctr_t;
  localparam bht_ctr_t BHT_STRONG_NT = 2'b00;
  localparam bht_ctr_t BHT_WEAK_NT   = 2'b01;
  localparam bht_ctr_t BHT_WEAK_T    = 2'b10;
  localparam bht_ctr_t BHT_STRONG_T  = 2'b11;
endpackage

// File: rtl/rv32i_bht_counter.sv
// rv32i_bht_counter: 2-bit saturating counter next-state for one resolved branch outcome.
module rv32i_bht_counter
  import rv32i_pkg::*;
(
  input  bht_ctr_t ctr_i,
  input  logic     taken_i,
  output bht_ctr_t ctr_nxt_o
);
  always_comb begin
    ctr_nxt_o = taken_i ? ((ctr_i == BHT_STRONG_T)  ? ctr_i : ctr_i + 2'd1)
                        : ((ctr_i == BHT_STRONG_NT) ? ctr_i : ctr_i - 2'd1);
  end
endmodule

// File: rtl/rv32i_branch_predictor.sv
// rv32i_branch_predictor: 2-bit BHT + direct-mapped BTB fetch predictor, trained from execute.
module rv32i_branch_predictor
  import rv32i_pkg::*;
#(
  parameter int BHT_ENTRIES = 64,
  parameter int BTB_ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fetch_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic        flush_btb,
  output logic [31:0] mispredict_cnt
);
  localparam int HW = $clog2(BHT_ENTRIES);
  localparam int BW = $clog2(BTB_ENTRIES);
  localparam int TW = 30 - BW;
  bht_ctr_t          bht_q     [BHT_ENTRIES];
  logic [BTB_ENTRIES-1:0] btb_v_q;
  logic [TW-1:0]     btb_tag_q [BTB_ENTRIES];
  logic [31:0]       btb_tgt_q [BTB_ENTRIES];
  logic [31:0]       cnt_q, cnt_d;
  logic [HW-1:0]     fhi, uhi;
  logic [BW-1:0]     fbi, ubi;
  logic              btb_hit;
  bht_ctr_t          ctr_nxt;
  logic              unused_lsb;
  assign fhi = fetch_pc[HW+1:2];
  assign fbi = fetch_pc[BW+1:2];
  assign uhi = upd_pc[HW+1:2];
  assign ubi = upd_pc[BW+1:2];
  assign unused_lsb = ^{fetch_pc[1:0], upd_pc[1:0]};
  assign btb_hit = btb_v_q[fbi] && (btb_tag_q[fbi] == fetch_pc[31:BW+2]);
  assign pred_taken = btb_hit && bht_q[fhi][1];
  assign pred_target = pred_taken ? btb_tgt_q[fbi] : 32'h0;
  assign mispredict_cnt = cnt_q;
  assign cnt_d = (upd_valid && (upd_taken != upd_pred_taken)) ? cnt_q + 32'd1 : cnt_q;
  rv32i_bht_counter u_ctr (
    .ctr_i     (bht_q[uhi]),
    .taken_i   (upd_taken),
    .ctr_nxt_o (ctr_nxt)
  );
  // Lookup reads flop state only, so a same-cycle update is seen from the next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= BHT_WEAK_NT;
      btb_v_q <= '0;
      cnt_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      if (upd_valid) bht_q[uhi] <= ctr_nxt;
      if (flush_btb) btb_v_q <= '0;
      else if (upd_valid && upd_taken) begin
        btb_v_q[ubi]   <= 1'b1;
        btb_tag_q[ubi] <= upd_pc[31:BW+2];
        btb_tgt_q[ubi] <= upd_target;
      end
    end
  end
endmodule

// File: tb/tb_rv32i_branch_predictor.sv
// tb_rv32i_branch_predictor: directed plus random stimulus against an array-based predictor model.
module tb_rv32i_branch_predictor;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] fetch_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_pred_taken = 1'b0;
  logic        flush_btb = 1'b0;
  logic [31:0] mispredict_cnt;
  int vectors = 0;
  int errors = 0;
  int          m_ctr [64];
  bit          m_val [16];
  logic [31:0] m_tag [16];
  logic [31:0] m_tgt [16];
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  rv32i_branch_predictor dut (
    .clk            (clk),
    .rst            (rst),
    .fetch_pc       (fetch_pc),
    .pred_taken     (pred_taken),
    .pred_target    (pred_target),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .upd_pred_taken (upd_pred_taken),
    .flush_btb      (flush_btb),
    .mispredict_cnt (mispredict_cnt)
  );

  function automatic bit m_pred(input logic [31:0] pc);
    int b = (pc >> 2) % 16;
    int h = (pc >> 2) % 64;
    return m_val[b] && (m_tag[b] == (pc >> 6)) && (m_ctr[h] >= 2);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 64; i++) m_ctr[i] = 1;
    for (int i = 0; i < 16; i++) m_val[i] = 0;
    m_cnt = 0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Drive one cycle, check the pre-edge lookup, then advance the model at the edge.
  task automatic step(input bit r, input bit uv, input logic [31:0] upc, input bit ut,
                      input logic [31:0] utgt, input bit upt, input bit fl, input logic [31:0] fpc);
    bit exp_t;
    int b, h;
    rst = r; upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
    upd_pred_taken = upt; flush_btb = fl; fetch_pc = fpc;
    @(negedge clk);
    exp_t = m_pred(fpc);
    chk("pred_taken", {31'b0, pred_taken}, {31'b0, exp_t});
    chk("pred_target", pred_target, exp_t ? m_tgt[(fpc >> 2) % 16] : 32'h0);
    chk("mispredict_cnt", mispredict_cnt, m_cnt);
    @(posedge clk);
    if (r) m_reset();
    else if (uv) begin
      h = (upc >> 2) % 64;
      b = (upc >> 2) % 16;
      m_ctr[h] = ut ? ((m_ctr[h] < 3) ? m_ctr[h] + 1 : 3) : ((m_ctr[h] > 0) ? m_ctr[h] - 1 : 0);
      if (ut != upt) m_cnt = m_cnt + 1;
      if (ut && !fl) begin
        m_val[b] = 1;
        m_tag[b] = upc >> 6;
        m_tgt[b] = utgt;
      end
    end
    if (!r && fl) for (int i = 0; i < 16; i++) m_val[i] = 0;
    #1;
  endtask

  task automatic look(input logic [31:0] fpc);
    step(0, 0, 0, 0, 0, 0, 0, fpc);
  endtask

  function automatic logic [31:0] pick();
    int s = $urandom_range(0, 3);
    if (s == 0) return 32'h1000 + 4 * $urandom_range(0, 7);
    if (s == 1) return 32'h1040 + 4 * $urandom_range(0, 7);
    if (s == 2) return 32'h1000 + 4 * $urandom_range(0, 7) + $urandom_range(0, 3);
    return $urandom();
  endfunction

  initial begin
    m_reset();
    @(posedge clk);
    #1;
    look(32'h1000);
    step(0, 1, 32'h1000, 1, 32'h2000, 0, 0, 32'h1000);
    look(32'h1000);
    chk("t2_taken", {31'b0, pred_taken}, 32'h1);
    chk("t2_target", pred_target, 32'h2000);
    chk("t2_cnt", mispredict_cnt, 32'h1);
    repeat (3) step(0, 1, 32'h1000, 0, 32'h0, 1, 0, 32'h1000);
    look(32'h1000);
    chk("t3_sat_nt", {31'b0, pred_taken}, 32'h0);
    repeat (2) step(0, 1, 32'h1000, 1, 32'h2000, 0, 0, 32'h1000);
    look(32'h1000);
    chk("t3_retaken", {31'b0, pred_taken}, 32'h1);
    step(0, 1, 32'h1040, 1, 32'h3000, 0, 0, 32'h1040);
    step(0, 1, 32'h1040, 1, 32'h3000, 1, 0, 32'h1040);
    look(32'h1000);
    look(32'h1040);
    chk("t4_alias_tgt", pred_target, 32'h3000);
    step(0, 1, 32'h1040, 0, 32'h0, 1, 0, 32'h1040);
    step(0, 1, 32'h1044, 1, 32'h4000, 0, 1, 32'h1044);
    look(32'h1040);
    look(32'h1044);
    chk("t5_flush", {31'b0, pred_taken}, 32'h0);
    step(0, 1, 32'h1044, 1, 32'h4000, 0, 0, 32'h1044);
    look(32'h1044);
    chk("t5_ctr_adv", {31'b0, pred_taken}, 32'h1);
    step(1, 1, 32'h1044, 0, 32'h0, 1, 0, 32'h1044);
    look(32'h1044);
    chk("t6_rst_cnt", mispredict_cnt, 32'h0);
    for (int n = 0; n < 400; n++)
      step($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, pick(), $urandom_range(0, 2) != 0,
           $urandom() & 32'hFFFF_FFFC, $urandom_range(0, 1), $urandom_range(0, 29) == 0, pick());
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
